seq_alu_unit: RTL

//   Multi-cycle, digit-serial ALU that answers operation requests over a valid/ready handshake.
//   It accepts {a, b, op} and computes z plus a zero flag DIGIT bits per cycle.
//   It returns the result on a held response channel until the consumer takes it.
//   It implements the same op encoding and results as the combinational yAlu.
//   It sits between the execute-stage issue logic and writeback, in place of yAlu on area-limited builds.

---
 rtl/seq_alu_unit_if.sv | 26 ++
 rtl/seq_alu_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_alu_unit_if.sv
// Request/response bundle for the digit-serial ALU: valid/ready request with
// operands and op, held valid/ready response with result and flags.
interface seq_alu_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic             rsp_zero;
    logic             rsp_illegal;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_zero, rsp_illegal
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/seq_alu_unit.sv
// Digit-serial ALU (and/or/add/sub/slt): consumes DIGIT operand bits per cycle,
// LSB digit first, and presents the result on a held response channel.
module seq_alu_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_alu_unit_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    logic [DIGIT-1:0] a_dig, b_dig, b_eff, dig_res;
    logic [DIGIT:0]   dig_sum;
    logic [WIDTH-1:0] acc_full, result;
    logic             lt;
    logic             req_legal;
    logic             req_is_sub;

    // Operands shift right each RUN cycle, so the low digit is always the
    // current one and, on the last digit, its top bit is the operand sign.
    always_comb begin
        a_dig    = a_q[DIGIT-1:0];
        b_dig    = b_q[DIGIT-1:0];
        b_eff    = op_q[2] ? ~b_dig : b_dig;
        dig_sum  = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
        case (op_q)
            OP_AND:  dig_res = a_dig & b_dig;
            OP_OR:   dig_res = a_dig | b_dig;
            default: dig_res = dig_sum[DIGIT-1:0];
        endcase
        acc_full = (acc_q >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
        lt       = (a_dig[DIGIT-1] != b_dig[DIGIT-1]) ? a_dig[DIGIT-1] : dig_sum[DIGIT-1];
        result   = (op_q == OP_SLT) ? WIDTH'(lt) : acc_full;
    end

    always_comb begin
        req_is_sub = (bus.req_op == OP_SUB) || (bus.req_op == OP_SLT);
        req_legal  = (bus.req_op == OP_AND) || (bus.req_op == OP_OR) ||
                     (bus.req_op == OP_ADD) || req_is_sub;
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        carry_d       = carry_q;
        a_d           = a_q;
        b_d           = b_q;
        acc_d         = acc_q;
        op_d          = op_q;
        rsp_z_d       = rsp_z_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    count_d = '0;
                    acc_d   = '0;
                    carry_d = req_is_sub;
                    if (req_legal) begin
                        state_d = S_RUN;
                    end else begin
                        state_d       = S_DONE;
                        rsp_z_d       = '0;
                        rsp_zero_d    = 1'b1;
                        rsp_illegal_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_sum[DIGIT];
                acc_d   = acc_full;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d       = S_DONE;
                    rsp_z_d       = result;
                    rsp_zero_d    = (result == '0);
                    rsp_illegal_d = 1'b0;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            carry_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            op_q          <= '0;
            rsp_z_q       <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            carry_q       <= carry_d;
            a_q           <= a_d;
            b_q           <= b_d;
            acc_q         <= acc_d;
            op_q          <= op_d;
            rsp_z_q       <= rsp_z_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.rsp_valid   = (state_q == S_DONE);
    assign bus.rsp_z       = rsp_z_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_illegal = rsp_illegal_q;
endmodule
